sr04_scheduler: RTL
===================

# sr04_scheduler

Measurement scheduler for the HC-SR04 ultrasonic ranging controller. Issues single-cycle start pulses to the controller, either periodically (auto mode) or on a manual request, and enforces a minimum spacing between pings so echoes cannot overlap. Supervises each measurement with a timeout and latches completed distances with a valid strobe and a success counter. Sits between the user/control logic and the ranging controller's start/done/distance ports.

## Interface
- CLK_HZ, 100_000_000, clock frequency; one ms = CLK_HZ/1000 cycles (MS_CYC)
- PERIOD_MS, 100, auto-mode interval between start pulses
- GUARD_MS, 60, minimum interval between any two start pulses
- TIMEOUT_MS, 40, maximum wait for meas_done after a start pulse
- DIST_W, 24, distance width
- Constraint: TIMEOUT_MS < GUARD_MS <= PERIOD_MS; all derived cycle counts fit 32 bits
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- auto_en  in  1  level; 1 = periodic measurement enabled
- req  in  1  manual measurement request, sampled each cycle
- meas_done  in  1  one-cycle pulse from ranging controller: meas_dist valid
- meas_dist  in  DIST_W  distance from ranging controller
- meas_start  out  1  one-cycle start pulse to ranging controller
- dist_out  out  DIST_W  last successful distance, held
- dist_valid  out  1  one-cycle pulse when dist_out updates
- busy  out  1  1 in ISSUE or WAIT
- timeout_err  out  1  sticky; set on timeout, cleared by next success
- meas_count  out  16  successful measurements, wraps 65535 -> 0

## Operation
- States: IDLE, ISSUE, WAIT.
- since_start: 32-bit cycle counter; 0 in the meas_start cycle, +1 per cycle, saturates at all-ones (never wraps). Reset value all-ones, so the first start is never guard-blocked.
- pend: request latch; set by req in any state, cleared when ISSUE is entered. Multiple reqs before service coalesce into one measurement.
- IDLE -> ISSUE when since_start >= GUARD_CYC-1 and (pend or req or (auto_en and since_start >= PERIOD_CYC-1)). Otherwise stay.
- ISSUE: meas_start=1 for exactly one cycle, since_start cleared, -> WAIT.
- WAIT: meas_done -> dist_out <= meas_dist, dist_valid pulse, timeout_err cleared, meas_count+1, -> IDLE.
- WAIT: since_start reaches TIMEOUT_CYC-1 with no meas_done -> timeout_err set, dist_out and meas_count unchanged, -> IDLE.
- meas_done and timeout in same cycle: done wins.
- meas_done outside WAIT: ignored (no dist_valid, no count).
- req during ISSUE/WAIT: latched in pend, served after guard expires.
- auto_en dropped during WAIT: current measurement completes normally; no further auto starts.
- Reset (any state, asynchronous): state IDLE, pend 0, since_start all-ones; outputs meas_start 0, dist_out 0, dist_valid 0, busy 0, timeout_err 0, meas_count 0.

## Timing
- All outputs registered.
- req high at edge N in IDLE with guard satisfied -> meas_start high in cycle N+1, busy high from N+1.
- Consecutive meas_start pulses always >= GUARD_CYC cycles apart (rising to rising).
- auto_en held, no req: meas_start pulses exactly PERIOD_CYC cycles apart.
- meas_done sampled at edge M in WAIT -> dist_out, meas_count updated and dist_valid high in cycle M+1; busy low in M+1.
- Timeout: timeout_err rises exactly TIMEOUT_CYC cycles after the meas_start cycle; busy falls same cycle.
- Auto enabled from idle with saturated since_start -> first meas_start one cycle after auto_en sampled high.

## Test plan
Bench parameters: CLK_HZ=1000 (1 cycle/ms), PERIOD_MS=100, GUARD_MS=60, TIMEOUT_MS=40.
- Manual: req one cycle after reset; meas_done with meas_dist=24'h000123 10 cycles after meas_start -> single meas_start, dist_out=0x000123, one dist_valid pulse, meas_count=1, timeout_err=0.
- Auto: auto_en=1, controller answers every ping after 5 cycles -> meas_start spacing exactly 100 cycles over 5 pings, meas_count=5.
- Guard/coalesce: three req pulses within 20 cycles of a completed measurement -> exactly one extra meas_start, no earlier than 60 cycles after the previous one.
- Timeout: no meas_done after start -> timeout_err=1 exactly 40 cycles after meas_start, dist_out unchanged, meas_count unchanged; next good measurement clears timeout_err.
- Edge cases: meas_done in IDLE ignored; meas_done in the timeout cycle counts as success.
- Reset mid-WAIT: assert rst low 15 cycles after meas_start -> all outputs at reset values immediately; after release, req issues meas_start next cycle (no guard wait).

Source files
------------

// File: rtl/sr04_scheduler.sv
// sr04_scheduler: decides when the HC-SR04 ranging controller may fire.
// Start pulses come from a manual request or the auto-mode period. A guard
// interval keeps pings far enough apart that late echoes cannot alias into
// the next measurement. Each measurement is supervised by a timeout, and
// completed distances are latched with a valid strobe and a success counter.
//
// Handshake with the ranging controller: meas_start is a one-cycle pulse that
// launches exactly one measurement. meas_done is a one-cycle pulse that
// qualifies meas_dist in the same cycle. It is accepted only while the
// scheduler is waiting for a result; a meas_done seen at any other time is
// dropped. There is no back-pressure in either direction.

module sr04_scheduler #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned PERIOD_MS  = 100,
    parameter int unsigned GUARD_MS   = 60,
    parameter int unsigned TIMEOUT_MS = 40,
    parameter int unsigned DIST_W     = 24
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active low
    input  logic              auto_en,
    input  logic              req,
    input  logic              meas_done,
    input  logic [DIST_W-1:0] meas_dist,
    output logic              meas_start,
    output logic [DIST_W-1:0] dist_out,
    output logic              dist_valid,
    output logic              busy,
    output logic              timeout_err,
    output logic [15:0]       meas_count,
    output logic [1:0]        fsm_state     // debug view of the FSM state
);

    localparam int unsigned MS_CYC = CLK_HZ / 1000;

    // Limits are stored as "cycles - 1". since_start is 0 in the meas_start
    // cycle, so reaching N-1 means N cycles have gone by since that pulse.
    localparam logic [31:0] PERIOD_LIM  = 32'(PERIOD_MS * MS_CYC - 1);
    localparam logic [31:0] GUARD_LIM   = 32'(GUARD_MS * MS_CYC - 1);
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_MS * MS_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       since_start;
    logic              pend;

    logic              guard_ok;
    logic              period_due;
    logic              timed_out;
    logic              enter_issue;
    logic              done_ok;
    logic              to_err;

    logic              start_d;
    logic              busy_d;
    logic              valid_d;
    logic              err_d;
    logic [DIST_W-1:0] dist_d;
    logic [15:0]       count_d;

    assign fsm_state = state;

    // Decode the interval counter into guard, period and timeout conditions.
    always_comb begin
        guard_ok   = (since_start >= GUARD_LIM);
        period_due = (since_start >= PERIOD_LIM);
        timed_out  = (since_start >= TIMEOUT_LIM);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A result arriving in the timeout cycle counts as a
    // success, so meas_done is tested before the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (guard_ok && (pend || req || (auto_en && period_due))) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (meas_done || timed_out) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Classify the events of the current cycle for the counter, latch and outputs.
    always_comb begin
        enter_issue = (state == S_IDLE) && (state_nxt == S_ISSUE);
        done_ok     = (state == S_WAIT) && meas_done;
        to_err      = (state == S_WAIT) && !meas_done && timed_out;
    end

    // Interval counter: cleared on the edge that enters ISSUE, so it reads 0
    // in the meas_start cycle. It saturates instead of wrapping, so a long
    // idle period never makes the guard look unsatisfied.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            since_start <= '1;
        end else if (enter_issue) begin
            since_start <= '0;
        end else if (since_start != '1) begin
            since_start <= since_start + 32'd1;
        end
    end

    // Request latch: any number of reqs before service collapse into one ping.
    // A req seen on the edge that enters ISSUE is served by that ping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= 1'b0;
        end else if (enter_issue) begin
            pend <= 1'b0;
        end else if (req) begin
            pend <= 1'b1;
        end
    end

    // Output logic: next values of the registered outputs, taken from the
    // next state and from this cycle's events.
    always_comb begin
        start_d = (state_nxt == S_ISSUE);
        busy_d  = (state_nxt != S_IDLE);
        valid_d = done_ok;
        dist_d  = dist_out;
        count_d = meas_count;
        err_d   = timeout_err;
        if (done_ok) begin
            dist_d  = meas_dist;
            count_d = meas_count + 16'd1;
            err_d   = 1'b0;
        end else if (to_err) begin
            err_d   = 1'b1;
        end
    end

    // Output registers: every port changes only on a clock edge or on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meas_start  <= 1'b0;
            busy        <= 1'b0;
            dist_valid  <= 1'b0;
            dist_out    <= '0;
            meas_count  <= '0;
            timeout_err <= 1'b0;
        end else begin
            meas_start  <= start_d;
            busy        <= busy_d;
            dist_valid  <= valid_d;
            dist_out    <= dist_d;
            meas_count  <= count_d;
            timeout_err <= err_d;
        end
    end

endmodule
